// File: rtl/conv_out_pkg.sv
// conv_out_pkg: shared FSM states, config selectors and activation defaults for conv_requant_store
package conv_out_pkg;
  typedef enum logic [2:0] {IDLE, RUN, WRITE, FLUSH, DONE} state_t;
  localparam logic [2:0] CFG_BASE    = 3'd0;
  localparam logic [2:0] CFG_OFFSET  = 3'd1;
  localparam logic [2:0] CFG_ACT_MIN = 3'd2;
  localparam logic [2:0] CFG_ACT_MAX = 3'd3;
  localparam logic [2:0] CFG_COUNT   = 3'd4;
  localparam logic [2:0] CFG_START   = 3'd5;
  localparam logic [31:0] ACT_MIN_DEF = 32'hffffff80;
  localparam logic [31:0] ACT_MAX_DEF = 32'd127;
endpackage

// File: rtl/requant_pipe.sv
// requant_pipe: four-stage TFLite requantization (bias, SRDHM, rounding shift, offset+clamp) with stall
module requant_pipe #(
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    in_valid,
  input  logic signed [31:0]      in_acc,
  input  logic signed [31:0]      in_bias,
  input  logic signed [31:0]      in_mult,
  input  logic signed [5:0]       in_shift,
  input  logic signed [31:0]      output_offset,
  input  logic signed [31:0]      act_min,
  input  logic signed [31:0]      act_max,
  output logic                    in_free,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_data
);
  logic v1, v2, v3, f2, f3, f4;
  logic signed [31:0] x1, m1, x2, x3, xs, srd, x3n, y;
  logic signed [5:0] sh1, sh2;
  logic signed [63:0] p, nudged;
  logic [31:0] mask, rem, thr;
  logic [5:0] r;
  // each stage loads only when the stage below it is empty or draining
  always_comb begin
    f4 = !out_valid || !stall;
    f3 = !v3 || f4;
    f2 = !v2 || f3;
    in_free = !v1 || f2;
    xs = x1 <<< (sh1[5] ? 6'd0 : $unsigned(sh1));
    p = 64'(xs) * 64'(m1);
    nudged = p + (p[63] ? -64'sd1073741823 : 64'sd1073741824);
    srd = (xs == 32'sh80000000 && m1 == 32'sh80000000) ? 32'sh7fffffff
        : 32'((nudged + (nudged[63] ? 64'sd2147483647 : 64'sd0)) >>> 31);
    r = sh2[5] ? 6'(-sh2) : 6'd0;
    mask = (32'd1 << r) - 32'd1;
    rem = x2 & mask;
    thr = (mask >> 1) + {31'd0, x2[31]};
    x3n = (x2 >>> r) + $signed({31'd0, rem > thr});
    y = x3 + output_offset;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {v1, v2, v3, out_valid} <= '0;
      {x1, m1, x2, x3} <= '0;
      {sh1, sh2} <= '0;
      out_data <= '0;
    end else begin
      if (in_free) begin
        v1 <= in_valid;
        x1 <= in_acc + in_bias;
        m1 <= in_mult;
        sh1 <= in_shift;
      end
      if (f2) begin
        v2 <= v1;
        x2 <= srd;
        sh2 <= sh1;
      end
      if (f3) begin
        v3 <= v2;
        x3 <= x3n;
      end
      if (f4) begin
        out_valid <= v3;
        out_data <= OUT_W'(y < act_min ? act_min : (y > act_max ? act_max : y));
      end
    end
  end
endmodule

// File: rtl/conv_requant_store.sv
// conv_requant_store: requantizes conv accumulators to int8 and writes packed words over Wishbone
module conv_requant_store
  import conv_out_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  input  logic [2:0]  cfg_sel,
  input  logic [31:0] cfg_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_acc,
  input  logic [31:0] in_bias,
  input  logic [31:0] in_mult,
  input  logic [5:0]  in_shift,
  output logic [29:0] wb_adr,
  output logic [31:0] wb_dat_mosi,
  output logic [3:0]  wb_sel,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  input  logic        wb_ack,
  input  logic        wb_err,
  output logic        busy,
  output logic        done
);
  state_t state;
  logic [29:0] base;
  logic signed [31:0] output_offset, act_min, act_max;
  logic [31:0] cnt, in_cnt, pk_cnt;
  logic pipe_free, pv, accept;
  logic [OUT_W-1:0] pb;
  logic [1:0] lane;
  assign lane = pk_cnt[1:0];
  assign in_ready = state == RUN && pipe_free && in_cnt != cnt;
  assign accept = in_valid && in_ready;
  assign wb_we = wb_cyc;
  requant_pipe #(.OUT_W(OUT_W)) u_pipe (
    .clk(clk), .reset(reset), .stall(state != RUN), .in_valid(accept),
    .in_acc(in_acc), .in_bias(in_bias), .in_mult(in_mult), .in_shift(in_shift),
    .output_offset(output_offset), .act_min(act_min), .act_max(act_max),
    .in_free(pipe_free), .out_valid(pv), .out_data(pb)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      base <= '0;
      output_offset <= '0;
      act_min <= ACT_MIN_DEF;
      act_max <= ACT_MAX_DEF;
      {cnt, in_cnt, pk_cnt} <= '0;
      {wb_adr, wb_dat_mosi, wb_sel} <= '0;
      {wb_cyc, wb_stb, busy, done} <= '0;
    end else begin
      if (accept) in_cnt <= in_cnt + 32'd1;
      case (state)
        IDLE: if (cfg_valid) begin
          if (cfg_sel == CFG_BASE) base <= cfg_data[31:2];
          if (cfg_sel == CFG_OFFSET) output_offset <= cfg_data;
          if (cfg_sel == CFG_ACT_MIN) act_min <= cfg_data;
          if (cfg_sel == CFG_ACT_MAX) act_max <= cfg_data;
          if (cfg_sel == CFG_COUNT) cnt <= cfg_data;
          if (cfg_sel == CFG_START) begin
            in_cnt <= '0;
            pk_cnt <= '0;
            busy <= 1'b1;
            done <= cnt == 32'd0;
            state <= cnt == 32'd0 ? DONE : RUN;
          end
        end
        RUN: if (pv) begin
          wb_dat_mosi <= wb_dat_mosi | ({{(32-OUT_W){1'b0}}, pb} << (lane * OUT_W));
          wb_sel <= wb_sel | (4'b0001 << lane);
          wb_adr <= base + pk_cnt[31:2];
          pk_cnt <= pk_cnt + 32'd1;
          if (lane == 2'd3 || pk_cnt == cnt - 32'd1) begin
            wb_cyc <= 1'b1;
            wb_stb <= 1'b1;
            state <= WRITE;
          end
        end
        WRITE: if (wb_ack) begin
          {wb_cyc, wb_stb} <= '0;
          wb_dat_mosi <= '0;
          wb_sel <= '0;
          done <= pk_cnt == cnt;
          state <= pk_cnt == cnt ? DONE : RUN;
        end else if (wb_err) begin
          {wb_cyc, wb_stb} <= '0;
          state <= FLUSH;
        end
        // the word is still held in wb_adr/dat/sel, so re-presenting it is just raising the strobe
        FLUSH: begin
          {wb_cyc, wb_stb} <= 2'b11;
          state <= WRITE;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_requant_store.sv
// tb_conv_requant_store: scoreboard bench for requantization, packing, Wishbone retry and reset
module tb_conv_requant_store;
  import conv_out_pkg::*;
  typedef struct packed {logic [29:0] adr; logic [31:0] dat; logic [3:0] sel;} wr_t;
  logic clk = 1'b0, reset = 1'b1;
  logic cfg_valid = 1'b0, in_valid = 1'b0;
  logic [2:0] cfg_sel = '0;
  logic [31:0] cfg_data = '0, in_acc = '0, in_bias = '0, in_mult = '0;
  logic [5:0] in_shift = '0;
  logic in_ready, wb_cyc, wb_stb, wb_we, busy, done;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_mosi;
  logic [3:0] wb_sel;
  logic wb_ack = 1'b0, wb_err = 1'b0;
  wr_t expq[$], obsq[$], errq[$];
  int n_chk = 0, n_pass = 0, err_budget = 0, done_cnt = 0, cyc_cnt = 0, stall_viol = 0;
  bit hold_ack = 1'b0;
  logic [31:0] a_acc[16], a_bias[16], a_mult[16];
  logic [5:0] a_sh[16];
  logic [31:0] m_base = '0;
  int m_off = 0, m_min = -128, m_max = 127;

  always #5 clk = ~clk;

  conv_requant_store #(.OUT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_bias(in_bias),
    .in_mult(in_mult), .in_shift(in_shift), .wb_adr(wb_adr), .wb_dat_mosi(wb_dat_mosi),
    .wb_sel(wb_sel), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack),
    .wb_err(wb_err), .busy(busy), .done(done)
  );

  // Wishbone slave: answers each strobe cycle, optionally with err first
  always @(negedge clk) begin
    wb_ack = 1'b0;
    wb_err = 1'b0;
    if (done) done_cnt++;
    if (wb_cyc) cyc_cnt++;
    if (wb_cyc && in_ready) stall_viol++;
    if (wb_cyc && wb_stb && !hold_ack && !reset) begin
      if (err_budget > 0) begin
        wb_err = 1'b1;
        err_budget--;
        errq.push_back(wr_t'({wb_adr, wb_dat_mosi, wb_sel}));
      end else begin
        wb_ack = 1'b1;
        obsq.push_back(wr_t'({wb_adr, wb_dat_mosi, wb_sel}));
      end
    end
  end

  function automatic logic [7:0] model(input logic [31:0] acc, bias, mult, input logic [5:0] sh);
    int x, s, q, y, shi;
    longint p, rem, half;
    shi = int'($signed(sh));
    x = int'(acc + bias);
    if (shi > 0) x = x << shi;
    if (x == int'(32'h80000000) && mult == 32'h80000000) s = 32'h7fffffff;
    else begin
      p = longint'(x) * longint'($signed(mult));
      s = int'((p + (p >= 0 ? 64'sd1073741824 : -64'sd1073741823)) / 64'sd2147483648);
    end
    if (shi < 0) begin
      q = s >>> (-shi);
      rem = longint'(s) - (longint'(q) <<< (-shi));
      half = 64'sd1 <<< (-shi);
      if (s >= 0 ? 2 * rem >= half : 2 * rem > half) q++;
      s = q;
    end
    y = s + m_off;
    y = y < m_min ? m_min : (y > m_max ? m_max : y);
    return y[7:0];
  endfunction

  task automatic cfg(input logic [2:0] sel, input logic [31:0] d);
    cfg_sel = sel;
    cfg_data = d;
    cfg_valid = 1'b1;
    if (sel == CFG_BASE) m_base = d;
    if (sel == CFG_OFFSET) m_off = d;
    if (sel == CFG_ACT_MIN) m_min = d;
    if (sel == CFG_ACT_MAX) m_max = d;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send(input int k);
    int t = 0;
    in_acc = a_acc[k];
    in_bias = a_bias[k];
    in_mult = a_mult[k];
    in_shift = a_sh[k];
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_model(input int n);
    wr_t w = '0;
    for (int k = 0; k < n; k++) begin
      w.adr = m_base[31:2] + 30'(k / 4);
      w.dat[8*(k%4) +: 8] = model(a_acc[k], a_bias[k], a_mult[k], a_sh[k]);
      w.sel[k%4] = 1'b1;
      if (k % 4 == 3 || k == n - 1) begin expq.push_back(w); w = '0; end
    end
  endtask

  task automatic run_job(input int n, output bit ok);
    int t = 0;
    done_cnt = 0;
    cfg(CFG_COUNT, 32'(n));
    cfg(CFG_START, 32'd0);
    for (int k = 0; k < n; k++) send(k);
    while (!done && t < 500) begin @(negedge clk); t++; end
    ok = done;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_elem(input int k, input logic [31:0] acc, bias, mult, input logic [5:0] sh);
    a_acc[k] = acc;
    a_bias[k] = bias;
    a_mult[k] = mult;
    a_sh[k] = sh;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++; if ({in_ready, wb_cyc, wb_stb, wb_we, busy, done} !== 6'b0) $display("FAIL reset_ctrl got %b want 000000", {in_ready, wb_cyc, wb_stb, wb_we, busy, done}); else n_pass++;
    n_chk++; if (wb_adr !== '0) $display("FAIL reset_adr got %h want 0", wb_adr); else n_pass++;
    n_chk++; if (wb_dat_mosi !== '0) $display("FAIL reset_dat got %h want 0", wb_dat_mosi); else n_pass++;
    n_chk++; if (wb_sel !== '0) $display("FAIL reset_sel got %b want 0000", wb_sel); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if ({in_ready, busy, wb_cyc} !== 3'b0) $display("FAIL reset_idle got %b want 000", {in_ready, busy, wb_cyc}); else n_pass++;
  endtask

  task automatic test_saturation();
    bit ok;
    wr_t e, o;
    set_elem(0, 32'h80000000, 32'd0, 32'h80000000, 6'd0);
    expq.push_back(wr_t'({30'h0, 32'h0000007f, 4'b0001}));
    run_job(1, ok);
    n_chk++; if (!ok || done_cnt != 1 || obsq.size() != 1) $display("FAIL sat_tail got ok=%0d done_cnt=%0d writes=%0d want 1/1/1", ok, done_cnt, obsq.size()); else n_pass++;
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = 'x; if (obsq.size() > 0) o = obsq.pop_front();
      n_chk++; if (o !== e) $display("FAIL sat_word got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_identity();
    bit ok;
    wr_t e, o;
    cfg(CFG_BASE, 32'h1000); cfg(CFG_OFFSET, 32'd0); cfg(CFG_ACT_MIN, -128); cfg(CFG_ACT_MAX, 127);
    for (int k = 0; k < 6; k++) set_elem(k, 32'(k + 1), 32'd0, 32'h7fffffff, 6'd0);
    expq.push_back(wr_t'({30'h400, 32'h04030201, 4'b1111}));
    expq.push_back(wr_t'({30'h401, 32'h00000605, 4'b0011}));
    run_job(6, ok);
    n_chk++; if (!ok || done_cnt != 1 || obsq.size() != 2) $display("FAIL identity_tail got ok=%0d done_cnt=%0d writes=%0d want 1/1/2", ok, done_cnt, obsq.size()); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL identity_busy got %b want 0", busy); else n_pass++;
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = 'x; if (obsq.size() > 0) o = obsq.pop_front();
      n_chk++; if (o !== e) $display("FAIL identity_word got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_clamp();
    bit ok;
    wr_t e, o;
    cfg(CFG_OFFSET, -128);
    set_elem(0, 32'd1000, 32'd24, 32'h40000000, 6'h3f);
    expq.push_back(wr_t'({30'h400, 32'h0000007f, 4'b0001}));
    run_job(1, ok);
    n_chk++; if (!ok || done_cnt != 1) $display("FAIL clamp_done got ok=%0d done_cnt=%0d want 1/1", ok, done_cnt); else n_pass++;
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = 'x; if (obsq.size() > 0) o = obsq.pop_front();
      n_chk++; if (o !== e) $display("FAIL clamp_word got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_neg_round();
    bit ok;
    wr_t e, o;
    cfg(CFG_ACT_MIN, -128);
    set_elem(0, -300, 32'd0, 32'h40000000, 6'd0);
    expq.push_back(wr_t'({30'h400, 32'h00000080, 4'b0001}));
    run_job(1, ok);
    n_chk++; if (!ok || done_cnt != 1) $display("FAIL negrnd_done got ok=%0d done_cnt=%0d want 1/1", ok, done_cnt); else n_pass++;
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = 'x; if (obsq.size() > 0) o = obsq.pop_front();
      n_chk++; if (o !== e) $display("FAIL negrnd_word got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wr_t e, o;
    cfg(CFG_BASE, 32'h2003); cfg(CFG_OFFSET, -10); cfg(CFG_ACT_MIN, -100); cfg(CFG_ACT_MAX, 90);
    for (int k = 0; k < 11; k++)
      set_elem(k, 32'(int'($urandom_range(0, 4000)) - 2000), 32'(int'($urandom_range(0, 200)) - 100),
               32'($urandom_range(32'h20000000, 32'h7fffffff)), 6'(int'($urandom_range(0, 9)) - 6));
    push_model(11);
    run_job(11, ok);
    n_chk++; if (!ok || done_cnt != 1 || obsq.size() != 3) $display("FAIL b2b_tail got ok=%0d done_cnt=%0d writes=%0d want 1/1/3", ok, done_cnt, obsq.size()); else n_pass++;
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = 'x; if (obsq.size() > 0) o = obsq.pop_front();
      n_chk++; if (o !== e) $display("FAIL b2b_word got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_err_retry();
    bit ok;
    wr_t e, o;
    cfg(CFG_BASE, 32'h3000); cfg(CFG_OFFSET, 5); cfg(CFG_ACT_MIN, -128); cfg(CFG_ACT_MAX, 127);
    for (int k = 0; k < 5; k++)
      set_elem(k, 32'(int'($urandom_range(0, 2000)) - 1000), 32'd7, 32'h5a000000, 6'h3e);
    push_model(5);
    errq.delete();
    stall_viol = 0;
    err_budget = 1;
    run_job(5, ok);
    n_chk++; if (!ok || done_cnt != 1) $display("FAIL retry_done got ok=%0d done_cnt=%0d want 1/1", ok, done_cnt); else n_pass++;
    n_chk++; if (errq.size() != 1 || obsq.size() == 0 || errq[0] !== obsq[0]) $display("FAIL retry_same got errs=%0d first_err=%h first_ack=%h want 1 identical", errq.size(), errq.size() ? errq[0] : 'x, obsq.size() ? obsq[0] : 'x); else n_pass++;
    n_chk++; if (stall_viol != 0) $display("FAIL retry_stall got %0d cycles with in_ready during write want 0", stall_viol); else n_pass++;
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = 'x; if (obsq.size() > 0) o = obsq.pop_front();
      n_chk++; if (o !== e) $display("FAIL retry_word got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_reset_zero_count();
    int t = 0;
    hold_ack = 1'b1;
    cfg(CFG_COUNT, 32'd4);
    cfg(CFG_START, 32'd0);
    for (int k = 0; k < 4; k++) set_elem(k, 32'(k), 32'd0, 32'h7fffffff, 6'd0);
    for (int k = 0; k < 4; k++) send(k);
    while (!wb_stb && t < 100) begin @(negedge clk); t++; end
    n_chk++; if (wb_stb !== 1'b1) $display("FAIL rst_stb_rise got %b want 1", wb_stb); else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++; if ({wb_cyc, wb_stb, busy} !== 3'b0) $display("FAIL rst_async_drop got %b want 000", {wb_cyc, wb_stb, busy}); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    hold_ack = 1'b0;
    obsq.delete();
    expq.delete();
    cyc_cnt = 0;
    done_cnt = 0;
    cfg(CFG_COUNT, 32'd0);
    cfg_sel = CFG_START;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    n_chk++; if ({done, busy} !== 2'b11) $display("FAIL zero_done got done,busy=%b want 11", {done, busy}); else n_pass++;
    @(negedge clk);
    n_chk++; if ({done, busy} !== 2'b00) $display("FAIL zero_fall got done,busy=%b want 00", {done, busy}); else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++; if (cyc_cnt != 0 || obsq.size() != 0 || done_cnt != 1) $display("FAIL zero_quiet got cyc=%0d writes=%0d done_cnt=%0d want 0/0/1", cyc_cnt, obsq.size(), done_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_identity();
    test_clamp();
    test_neg_round();
    test_back_to_back();
    test_err_retry();
    test_reset_zero_count();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
